// File: rtl/updown_mirror_pkg.sv
// Shared types and constants for the loadable down counter.
// Holds the two-state run/halt enum and the mode encodings.
package updown_mirror_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/updown_mirror_counter.sv
// Loadable down counter with auto-reload or one-shot halt, registered tc pulse and sticky done.
// All outputs registered, one edge after qualifying inputs; no backpressure, en simply gates counting.
module updown_mirror_counter
    import updown_mirror_pkg::*;
#(
    parameter int               WIDTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             mode,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             done
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload_reg;
    state_t           state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= RESET_VALUE;
            reload_reg <= RESET_VALUE;
            tc         <= 1'b0;
            done       <= 1'b0;
            state      <= RUN;
        end else if (load) begin
            count      <= load_value;
            reload_reg <= load_value;
            tc         <= 1'b0;
            done       <= 1'b0;
            state      <= RUN;
        end else begin
            tc <= 1'b0;
            if (state == RUN && en) begin
                if (count != '0) begin
                    count <= count - 1'b1;
                end else begin
                    // Underflow edge: mode is only consulted here, so mid-count changes wait.
                    tc <= 1'b1;
                    if (mode == MODE_ONESHOT) begin
                        state <= HALT;
                        done  <= 1'b1;
                    end else begin
                        count <= reload_reg;
                    end
                end
            end
        end
    end

    assign count_out = count;

endmodule

// File: tb/tb_updown_mirror_counter.sv
// Randomized and directed bench for updown_mirror_counter against a behavioural model.
module tb_updown_mirror_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       load;
    logic [1:0] load_value;
    logic       mode;
    logic [1:0] count_out;
    logic       tc;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: plain integers following the counter's stated rules.
    int m_cnt;
    int m_rel;
    bit m_halted;
    bit m_tc;
    bit m_done;

    updown_mirror_counter dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load       (load),
        .load_value (load_value),
        .mode       (mode),
        .count_out  (count_out),
        .tc         (tc),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 3;
        m_rel    = 3;
        m_halted = 0;
        m_tc     = 0;
        m_done   = 0;
    endtask

    task automatic model_edge(input bit l, input int lv, input bit e, input bit md);
        m_tc = 0;
        if (l) begin
            m_cnt    = lv;
            m_rel    = lv;
            m_halted = 0;
            m_done   = 0;
        end else if (e && !m_halted) begin
            if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
            end else begin
                m_tc = 1;
                if (md) begin
                    m_halted = 1;
                    m_done   = 1;
                end else begin
                    m_cnt = m_rel;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, int'(count_out), m_cnt);
        chk({tag, ".tc"},    int'(tc),        int'(m_tc));
        chk({tag, ".done"},  int'(done),      int'(m_done));
    endtask

    // Called at a negedge: drive inputs, take the rising edge, check, return at next negedge.
    task automatic cyc(input string tag, input bit l, input int lv, input bit e, input bit md);
        load       = l;
        load_value = 2'(lv);
        en         = e;
        mode       = md;
        @(posedge clk);
        model_edge(l, lv, e, md);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    // Reset pulse raised between edges; outputs must change without a clock.
    task automatic mid_reset(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        en         = 1'b0;
        load       = 1'b0;
        load_value = 2'd0;
        mode       = 1'b0;
        model_reset();
        #1;
        chk("reset.count", int'(count_out), 3);
        chk("reset.tc",    int'(tc),        0);
        chk("reset.done",  int'(done),      0);
        #199;
        @(negedge clk);
        reset = 1'b0;

        // Free-run from reset value: period of four.
        for (int i = 0; i < 9; i++) cyc("freerun3", 0, 0, 1, 0);

        // Reload of 2 gives a period of three and persists across wraps.
        cyc("load2", 1, 2, 1, 0);
        for (int i = 0; i < 7; i++) cyc("freerun2", 0, 0, 1, 0);

        // One-shot from 3, then continued enable while halted.
        cyc("os_load3", 1, 3, 0, 1);
        for (int i = 0; i < 7; i++) cyc("oneshot", 0, 0, 1, 1);
        chk("oneshot.halt_count", int'(count_out), 0);
        chk("oneshot.halt_done",  int'(done),      1);
        cyc("os_load1", 1, 1, 1, 1);
        chk("os_load1.done_clr", int'(done), 0);
        for (int i = 0; i < 4; i++) cyc("oneshot1", 0, 0, 1, 1);

        // Gated enable from 3 gives 2,2,2,1 with no tc.
        cyc("gate_load3", 1, 3, 0, 0);
        cyc("gate1", 0, 0, 1, 0);
        cyc("gate0", 0, 0, 0, 0);
        cyc("gate0", 0, 0, 0, 0);
        cyc("gate1", 0, 0, 1, 0);
        chk("gate.count", int'(count_out), 1);
        chk("gate.tc",    int'(tc),        0);

        // Load beats decrement on the same edge.
        cyc("ld_en", 1, 3, 1, 0);
        chk("ld_en.count", int'(count_out), 3);

        // Reset mid-cycle with count 1 and reload 2; afterwards wrap goes to 3.
        cyc("pre_rst_load2", 1, 2, 0, 0);
        cyc("pre_rst_dec", 0, 0, 1, 0);
        chk("pre_rst.count", int'(count_out), 1);
        mid_reset("rst6");
        for (int i = 0; i < 4; i++) cyc("post_rst", 0, 0, 1, 0);
        chk("post_rst.wrap", int'(count_out), 3);

        // Reload of zero in free-run: tc high after every enabled edge.
        cyc("zero_load", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("zero_run", 0, 0, 1, 0);
        chk("zero_run.tc", int'(tc), 1);

        // Randomized traffic with occasional mid-cycle resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) == 0) begin
                mid_reset("rnd_rst");
            end else begin
                cyc("rnd",
                    ($urandom_range(7) == 0),
                    int'($urandom_range(3)),
                    ($urandom_range(3) != 0),
                    ($urandom_range(1) == 1));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
